// File: rtl/cmult_arbiter.sv
// ----------------------------------------------------------------------------
// cmult_arbiter
//
// Two requesters share one fully pipelined complex multiplier. A round-robin
// pointer picks a winner when both present operands; a lone requester is
// granted immediately. One operation can be accepted every cycle and each
// result appears exactly LAT cycles after acceptance, tagged with the owner.
//
// Ports
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   en                    grant enable (in-flight work always completes)
//   reqN_valid/ready      per-requester handshake (ready is combinational)
//   reqN_a, reqN_b        operands, {imag, real}, DW-bit two's complement
//   res_valid             one-cycle result strobe
//   res_id                index of the requester owning res_data
//   res_data              exact product, {imag, real}, (2*DW+1) bits each
//   busy                  at least one accepted operation still owed
//   issue_cnt             wrapping count of accepted operations
// ----------------------------------------------------------------------------
module cmult_arbiter #(
    parameter int DW  = 16,
    parameter int LAT = 3
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     en,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [2*DW-1:0]          req0_a,
    input  logic [2*DW-1:0]          req0_b,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [2*DW-1:0]          req1_a,
    input  logic [2*DW-1:0]          req1_b,
    output logic                     res_valid,
    output logic                     res_id,
    output logic [2*(2*DW+1)-1:0]    res_data,
    output logic                     busy,
    output logic [15:0]              issue_cnt
);

    localparam int PW = 2*DW + 1;

    // Exact complex product. Operands are sign-extended to PW bits first;
    // every partial product fits in 2*DW bits and each sum in PW bits, so
    // PW-bit modular arithmetic yields the exact result.
    function automatic logic [2*PW-1:0] cmul(input logic [2*DW-1:0] a,
                                             input logic [2*DW-1:0] b);
        logic signed [PW-1:0] a_re, a_im, b_re, b_im, re, im;
        a_re = {{(PW-DW){a[DW-1]}},   a[DW-1:0]};
        a_im = {{(PW-DW){a[2*DW-1]}}, a[2*DW-1:DW]};
        b_re = {{(PW-DW){b[DW-1]}},   b[DW-1:0]};
        b_im = {{(PW-DW){b[2*DW-1]}}, b[2*DW-1:DW]};
        re   = a_re * b_re - a_im * b_im;
        im   = a_re * b_im + a_im * b_re;
        return {im, re};
    endfunction

    logic                ptr;        // 0: requester 0 wins contention
    logic                grant0;
    logic                grant1;
    logic                xfer;

    // Valid/tag shift register, index = stage; stage 0 holds the operands.
    logic [LAT-1:0]      vld_p;
    logic [LAT-1:0]      id_p;

    logic [2*DW-1:0]     a_p0;
    logic [2*DW-1:0]     b_p0;
    logic [2*PW-1:0]     prod_p [1:LAT-1];

    // Grants are held low during reset so nothing is accepted while the
    // pipeline is being cleared.
    always_comb begin
        grant0 = ARESETN & en & req0_valid & (~req1_valid | ~ptr);
        grant1 = ARESETN & en & req1_valid & (~req0_valid |  ptr);
        xfer   = grant0 | grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Control path and output registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ptr       <= 1'b0;
            issue_cnt <= '0;
            vld_p     <= '0;
            id_p      <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_data  <= '0;
            busy      <= 1'b0;
        end else begin
            if (xfer) begin
                ptr       <= grant0;
                issue_cnt <= issue_cnt + 16'd1;
            end
            vld_p     <= {vld_p[LAT-2:0], xfer};
            id_p      <= {id_p[LAT-2:0], grant1};
            // busy mirrors the valid bits as they will be after this edge
            busy      <= |{vld_p[LAT-2:0], xfer};
            // stage LAT -> output
            res_valid <= vld_p[LAT-1];
            if (vld_p[LAT-1]) begin
                res_id   <= id_p[LAT-1];
                res_data <= prod_p[LAT-1];
            end
        end
    end

    // Datapath: stage 0 captures operands, stage 1 the product, then delay.
    always_ff @(posedge ACLK) begin
        if (xfer) begin
            a_p0 <= grant1 ? req1_a : req0_a;
            b_p0 <= grant1 ? req1_b : req0_b;
        end
        // stage 0 -> stage 1
        prod_p[1] <= cmul(a_p0, b_p0);
        // stage k-1 -> stage k
        for (int k = 2; k < LAT; k++) begin
            prod_p[k] <= prod_p[k-1];
        end
    end

endmodule

// File: tb/tb_cmult_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cmult_arbiter
//
// Scoreboard bench for cmult_arbiter (DW=16, LAT=3). A negedge monitor models
// the round-robin grant, pushes the expected product/owner/due-cycle of every
// accepted operation, and pops/compares when res_valid appears. Directed
// sequences cover the worked examples, contention order, enable gating,
// reset with work in flight, random traffic and the issue counter wrap.
// ----------------------------------------------------------------------------
module tb_cmult_arbiter;

    localparam int DW  = 16;
    localparam int LAT = 3;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        en;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_id, busy;
    logic [65:0] res_data;
    logic [15:0] issue_cnt;

    cmult_arbiter #(.DW(DW), .LAT(LAT)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .en         (en),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_data   (res_data),
        .busy       (busy),
        .issue_cnt  (issue_cnt)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          id;
        logic [65:0] data;
        int          due;
    } exp_t;

    exp_t        sbq [$];
    bit          id_log [$];
    int          cyc_log [$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          rv_count = 0;
    bit          ptr_m    = 1'b0;
    logic [15:0] cnt_m    = '0;
    logic [65:0] last_m   = '0;

    always @(posedge ACLK) cyc++;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Reference complex product using 64-bit integer arithmetic.
    function automatic logic [65:0] cm(input logic [31:0] a, input logic [31:0] b);
        longint ar, ai, br, bi, re, im;
        ar = longint'($signed(a[15:0]));
        ai = longint'($signed(a[31:16]));
        br = longint'($signed(b[15:0]));
        bi = longint'($signed(b[31:16]));
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {im[32:0], re[32:0]};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            2:       return 16'hffff;
            default: return 16'($urandom());
        endcase
    endfunction

    // Monitor / scoreboard
    always @(negedge ACLK) begin
        exp_t e;
        bit   g0, g1;
        if (!ARESETN) begin
            sbq.delete();
            ptr_m  = 1'b0;
            cnt_m  = '0;
            last_m = '0;
            chk("rst_ready", 128'({req0_ready, req1_ready}), 128'(0));
            chk("rst_ctrl",  128'({res_valid, res_id, busy}), 128'(0));
            chk("rst_cnt",   128'(issue_cnt), 128'(0));
            chk("rst_data",  128'(res_data), 128'(0));
        end else begin
            if (res_valid) begin
                rv_count++;
                if (sbq.size() == 0) begin
                    chk("spurious_res", 128'(1), 128'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("res_id",   128'(res_id), 128'(e.id));
                    chk("res_data", 128'(res_data), 128'(e.data));
                    chk("res_time", 128'(cyc), 128'(e.due));
                    last_m = e.data;
                    id_log.push_back(res_id);
                    cyc_log.push_back(cyc);
                end
            end else begin
                chk("res_hold", 128'(res_data), 128'(last_m));
                if (sbq.size() != 0 && sbq[0].due < cyc) begin
                    chk("res_missing", 128'(0), 128'(1));
                    void'(sbq.pop_front());
                end
            end
            chk("busy",      128'(busy), 128'(sbq.size() != 0));
            chk("issue_cnt", 128'(issue_cnt), 128'(cnt_m));
            g0 = en && req0_valid && (!req1_valid || !ptr_m);
            g1 = en && req1_valid && (!req0_valid ||  ptr_m);
            chk("ready", 128'({req0_ready, req1_ready}), 128'({g0, g1}));
            if (g0 || g1) begin
                e.id   = g1;
                e.data = g1 ? cm(req1_a, req1_b) : cm(req0_a, req0_b);
                e.due  = cyc + 1 + LAT;
                sbq.push_back(e);
                cnt_m++;
                ptr_m = g0;
            end
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        step();
        ARESETN    = 1'b0;
        en         = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) step();
        ARESETN = 1'b1;
    endtask

    task automatic wait_res(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge ACLK);
            if (res_valid) seen = 1'b1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit         seen;
        logic [5:0] order;
        logic [5:0] ids;
        ARESETN = 1'b1;
        en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #1 ARESETN = 1'b0;
        do_reset();
        @(negedge ACLK);
        chk("post_rst_cnt",  128'(issue_cnt), 128'(0));
        chk("post_rst_busy", 128'(busy), 128'(0));
        step();

        // (1+2j)*(3+4j) = -5+10j on requester 0
        req0_a = 32'h0002_0001; req0_b = 32'h0004_0003;
        req0_valid = 1'b1; en = 1'b1;
        step();
        req0_valid = 1'b0;
        wait_res(seen);
        chk("t033_seen", 128'(seen), 128'(1));
        chk("t033_id",   128'(res_id), 128'(0));
        chk("t033_data", 128'(res_data), 128'({33'd10, 33'h1_FFFF_FFFB}));
        step();

        // most negative operands on both parts
        req1_a = 32'h8000_8000; req1_b = 32'h8000_8000;
        req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        wait_res(seen);
        chk("t034_seen", 128'(seen), 128'(1));
        chk("t034_id",   128'(res_id), 128'(1));
        chk("t034_data", 128'(res_data), 128'({33'h0_8000_0000, 33'h0}));
        step();

        // contention from reset: alternating grants, back-to-back results
        do_reset();
        id_log.delete(); cyc_log.delete();
        order = '0;
        en = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_a = {rnd16(), rnd16()}; req0_b = {rnd16(), rnd16()};
            req1_a = {rnd16(), rnd16()}; req1_b = {rnd16(), rnd16()};
            @(negedge ACLK);
            order = {order[4:0], req1_ready};
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (LAT + 3) step();
        chk("t035_order", 128'(order), 128'(6'b010101));
        chk("t035_cnt",   128'(issue_cnt), 128'(6));
        chk("t035_nres",  128'(id_log.size()), 128'(6));
        if (id_log.size() == 6) begin
            ids = '0;
            for (int i = 0; i < 6; i++) ids = {ids[4:0], id_log[i]};
            chk("t035_ids",  128'(ids), 128'(6'b010101));
            chk("t035_span", 128'(cyc_log[5] - cyc_log[0]), 128'(5));
        end

        // three grants (0,1,0), then en low with both still asking
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) step();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("t036_blocked", 128'({req0_ready, req1_ready}), 128'(2'b00));
            step();
        end
        chk("t036_cnt", 128'(issue_cnt), 128'(9));
        en = 1'b1;
        @(negedge ACLK);
        chk("t036_resume", 128'({req0_ready, req1_ready}), 128'(2'b01));
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (LAT + 3) step();

        // reset while three operations are in flight
        req0_valid = 1'b1;
        repeat (3) step();
        req0_valid = 1'b0;
        ARESETN = 1'b0;
        repeat (2) step();
        ARESETN = 1'b1;
        rv_count = 0;
        repeat (LAT + 4) step();
        chk("t037_nres", 128'(rv_count), 128'(0));
        chk("t037_busy", 128'(busy), 128'(0));
        chk("t037_cnt",  128'(issue_cnt), 128'(0));

        // random traffic
        for (int i = 0; i < 300; i++) begin
            en         = ($urandom_range(0, 7) != 0);
            req0_valid = $urandom_range(0, 1) == 1;
            req1_valid = $urandom_range(0, 1) == 1;
            req0_a = {rnd16(), rnd16()}; req0_b = {rnd16(), rnd16()};
            req1_a = {rnd16(), rnd16()}; req1_b = {rnd16(), rnd16()};
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (LAT + 3) step();
        chk("rand_drain", 128'(sbq.size()), 128'(0));

        // counter wrap: 65537 transfers from reset
        do_reset();
        en = 1'b1; req0_valid = 1'b1;
        req0_a = 32'h1234_8765; req0_b = 32'hfedc_0101;
        repeat (65537) step();
        req0_valid = 1'b0;
        chk("t038_cnt", 128'(issue_cnt), 128'(1));
        repeat (LAT + 3) step();
        chk("t038_drain", 128'(sbq.size()), 128'(0));
        chk("t038_busy",  128'(busy), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmult_arbiter.md
CMULT_ARBITER -- requirements
Module: cmult_arbiter

Interface
REQ-001 Parameter DW, default 16, signed width of each real/imaginary operand component.
REQ-002 Parameter LAT, default 3, legal range 2..8, accept-to-result latency in ACLK cycles.
REQ-003 ACLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 ARESETN  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  grant enable; 0 blocks new grants, in-flight operations still complete.
REQ-006 req0_valid  input  1  requester 0 holds an operand pair.
REQ-007 req0_ready  output  1  requester 0 granted this cycle.
REQ-008 req0_a, req0_b  input  2*DW each  operands packed {imag, real}, two's complement.
REQ-009 req1_valid, req1_ready, req1_a, req1_b  same widths and meanings as REQ-006..008, for requester 1.
REQ-010 res_valid  output  1  one-cycle result strobe.
REQ-011 res_id  output  1  requester index that owns the result.
REQ-012 res_data  output  2*(2*DW+1)  product packed {imag, real}, full precision, signed.
REQ-013 busy  output  1  at least one operation in flight.
REQ-014 issue_cnt  output  16  count of accepted operations.

Function
REQ-015 Transfer on requester N: reqN_valid and reqN_ready both high at a rising edge; operands sampled at that edge.
REQ-016 reqN_ready is combinational from en, both valids and the priority pointer; it never depends on res_* signals.
REQ-017 At most one reqN_ready is high per cycle; reqN_ready is never high while reqN_valid is low or en is low.
REQ-018 Single valid requester with en=1: that requester is granted the same cycle, regardless of the pointer.
REQ-019 Both valid with en=1: grant goes to the requester the pointer favours; pointer updates on each transfer to favour the other requester.
REQ-020 Pointer holds when no transfer occurs; a requester therefore waits at most one grant under contention.
REQ-021 Throughput: one accepted operation per cycle; the multiplier pipeline never stalls.
REQ-022 Real part = a_re*b_re - a_im*b_im; imag part = a_re*b_im + a_im*b_re; exact in 2*DW+1 bits, no rounding, no saturation.
REQ-023 Operation accepted at edge t: res_valid is high for exactly the cycle after edge t+LAT-1, i.e. registered at edge t+LAT, with matching res_id and res_data.
REQ-024 Results leave in acceptance order; res_id is carried through an LAT-deep valid/tag shift register in step with the data.
REQ-025 res_data holds its last value while res_valid is low.
REQ-026 busy = OR of all pipeline valid bits, registered; busy is low exactly when no accepted operation is still owed a result.
REQ-027 issue_cnt increments by 1 on every transfer and wraps 16'hFFFF -> 0.
REQ-028 en deasserting mid-stream: no new grants from the next cycle; in-flight results still emerge on schedule.

Reset
REQ-029 ARESETN low asynchronously clears: pipeline valid bits, res_valid, res_id, res_data, busy, issue_cnt, to 0; pointer favours requester 0.
REQ-030 reqN_ready is low during reset.
REQ-031 Reset mid-operation: in-flight operations are discarded and produce no res_valid after release.
REQ-032 First grant is possible in the first cycle after ARESETN is sampled high.

Verification
REQ-033 DW=16, LAT=3: req0 a=(1+2j), b=(3+4j), accepted at edge t -> res_valid at edge t+3, res_id=0, res_data real=-5, imag=10.
REQ-034 Extremes: a=b=(-32768-32768j) -> real=0, imag=2147483648 (33-bit signed, no overflow).
REQ-035 Both requesters valid for 6 cycles from reset -> grant order 0,1,0,1,0,1; results in that order on 6 consecutive cycles; issue_cnt=6.
REQ-036 en=0 with both valid -> both ready low, issue_cnt unchanged; en=1 -> grant resumes at the pointer's favoured requester.
REQ-037 ARESETN pulsed low while 3 operations are in flight -> no res_valid follows, busy=0, issue_cnt=0.
REQ-038 65537 accepted operations -> issue_cnt=1.
